// File: rtl/memory_responder_pkg.sv
// Shared bus types for the memory responder: address/requester types, command and
// response encodings, the captured request packet and the responder FSM states.
package memory_responder_pkg;

   typedef logic [31:0] memory_address_t;
   typedef logic [3:0]  CoreID;

   localparam logic [1:0] CMD_READ      = 2'd0;
   localparam logic [1:0] CMD_WRITE     = 2'd1;

   localparam logic [1:0] RSP_ERROR     = 2'd0;
   localparam logic [1:0] RSP_READ_DATA = 2'd2;
   localparam logic [1:0] RSP_WRITE_ACK = 2'd3;

   typedef struct packed {
      logic [1:0]      cmd;
      memory_address_t address;
      CoreID           source;
      logic [63:0]     payload;
   } BusPacket;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_ACCESS  = 2'd2,
      ST_RESPOND = 2'd3
   } resp_state_e;

   // Word-aligned READ/WRITE only; anything else is answered with an error.
   function automatic logic is_legal(input BusPacket pkt);
      return (pkt.address[2:0] == 3'd0) &&
             ((pkt.cmd == CMD_READ) || (pkt.cmd == CMD_WRITE));
   endfunction

endpackage

// File: rtl/memory_word_array.sv
// Single-port WORDS x 64 backing store: synchronous write, registered read (data one
// cycle after the address). Contents are not reset.
module memory_word_array #(
   parameter int WORDS = 1024
) (
   input  logic                     clk,
   input  logic                     i_we,
   input  logic [$clog2(WORDS)-1:0] i_addr,
   input  logic [63:0]              i_wdat,
   output logic [63:0]              o_rdat
);

   logic [63:0] r_mem [WORDS];
   logic [63:0] r_rdat;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdat;
      end
      r_rdat <= r_mem[i_addr];
   end

   assign o_rdat = r_rdat;

endmodule

// File: rtl/memory_responder.sv
// One-at-a-time memory target: accept in IDLE, response valid READ_LATENCY+1 cycles later,
// held until rsp_taken; no new request is accepted while a response is outstanding.
module memory_responder
   import memory_responder_pkg::*;
#(
   parameter int MEM_WORDS    = 1024,
   parameter int READ_LATENCY = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [1:0]  req_cmd,
   input  logic [31:0] req_address,
   input  logic [3:0]  req_source,
   input  logic [63:0] req_payload,
   output logic        req_accept,
   output logic        rsp_valid,
   output logic [1:0]  rsp_cmd,
   output logic [31:0] rsp_address,
   output logic [3:0]  rsp_source,
   output logic [63:0] rsp_payload,
   input  logic        rsp_taken,
   output logic [31:0] num_reads,
   output logic [31:0] num_writes
);

   localparam int         AW       = $clog2(MEM_WORDS);
   localparam logic [7:0] LAT_INIT = 8'(READ_LATENCY - 1);

   resp_state_e     r_state;
   resp_state_e     w_next;
   BusPacket        r_req;
   logic [7:0]      r_lat_cnt;
   logic [1:0]      r_rsp_cmd;
   memory_address_t r_rsp_address;
   CoreID           r_rsp_source;
   logic [63:0]     r_rsp_payload;
   logic [31:0]     r_num_reads;
   logic [31:0]     r_num_writes;

   logic            w_accept;
   logic            w_legal;
   logic            w_mem_we;
   logic [AW-1:0]   w_mem_idx;
   logic [63:0]     w_mem_rdat;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // WAIT exits while the counter still reads 1 so it is 0 on entry to ACCESS; a latency
   // of 1 skips WAIT entirely to meet the accept-to-valid timing.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:    if (req_valid) w_next = (READ_LATENCY == 1) ? ST_ACCESS : ST_WAIT;
         ST_WAIT:    if (r_lat_cnt <= 8'd1) w_next = ST_ACCESS;
         ST_ACCESS:  w_next = ST_RESPOND;
         ST_RESPOND: if (rsp_taken) w_next = ST_IDLE;
         default:    w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_accept  = (r_state == ST_IDLE) && req_valid && !reset;
      w_legal   = is_legal(r_req);
      w_mem_we  = (r_state == ST_ACCESS) && w_legal && (r_req.cmd == CMD_WRITE);
      // In IDLE the array is pre-addressed from the live request so read data is ready
      // by ACCESS even at the minimum latency.
      w_mem_idx = (r_state == ST_IDLE) ? req_address[3 +: AW] : r_req.address[3 +: AW];
   end

   memory_word_array #(.WORDS(MEM_WORDS)) u_mem (
      .clk    (clk),
      .i_we   (w_mem_we),
      .i_addr (w_mem_idx),
      .i_wdat (r_req.payload),
      .o_rdat (w_mem_rdat)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_req         <= '0;
         r_lat_cnt     <= 8'd0;
         r_rsp_cmd     <= RSP_ERROR;
         r_rsp_address <= '0;
         r_rsp_source  <= '0;
         r_rsp_payload <= '0;
         r_num_reads   <= '0;
         r_num_writes  <= '0;
      end else begin
         if (w_accept) begin
            r_req     <= '{cmd: req_cmd, address: req_address,
                           source: req_source, payload: req_payload};
            r_lat_cnt <= LAT_INIT;
         end
         if ((r_state == ST_WAIT) && (r_lat_cnt != 8'd0)) begin
            r_lat_cnt <= r_lat_cnt - 8'd1;
         end
         if (r_state == ST_ACCESS) begin
            r_rsp_address <= r_req.address;
            r_rsp_source  <= r_req.source;
            if (!w_legal) begin
               r_rsp_cmd     <= RSP_ERROR;
               r_rsp_payload <= '0;
            end else if (r_req.cmd == CMD_READ) begin
               r_rsp_cmd     <= RSP_READ_DATA;
               r_rsp_payload <= w_mem_rdat;
            end else begin
               r_rsp_cmd     <= RSP_WRITE_ACK;
               r_rsp_payload <= r_req.payload;
            end
         end
         if ((r_state == ST_RESPOND) && rsp_taken) begin
            if (r_rsp_cmd == RSP_READ_DATA) r_num_reads  <= r_num_reads + 32'd1;
            if (r_rsp_cmd == RSP_WRITE_ACK) r_num_writes <= r_num_writes + 32'd1;
         end
      end
   end

   assign req_accept  = w_accept;
   assign rsp_valid   = (r_state == ST_RESPOND);
   assign rsp_cmd     = r_rsp_cmd;
   assign rsp_address = r_rsp_address;
   assign rsp_source  = r_rsp_source;
   assign rsp_payload = r_rsp_payload;
   assign num_reads   = r_num_reads;
   assign num_writes  = r_num_writes;

endmodule

// File: tb/tb_memory_responder.sv
// Directed and randomized checks of memory_responder against a word-array reference model.
module tb_memory_responder;
   import memory_responder_pkg::*;

   localparam int MEM_WORDS = 1024;
   localparam int LAT       = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic [1:0]  req_cmd;
   logic [31:0] req_address;
   logic [3:0]  req_source;
   logic [63:0] req_payload;
   logic        req_accept;
   logic        rsp_valid;
   logic [1:0]  rsp_cmd;
   logic [31:0] rsp_address;
   logic [3:0]  rsp_source;
   logic [63:0] rsp_payload;
   logic        rsp_taken;
   logic [31:0] num_reads;
   logic [31:0] num_writes;

   int n_assert = 0;
   int n_fail   = 0;

   logic [63:0] mdl_mem [int];
   logic [31:0] exp_reads  = 0;
   logic [31:0] exp_writes = 0;

   always #5 clk = ~clk;

   memory_responder #(.MEM_WORDS(MEM_WORDS), .READ_LATENCY(LAT)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_cmd(req_cmd), .req_address(req_address),
      .req_source(req_source), .req_payload(req_payload), .req_accept(req_accept),
      .rsp_valid(rsp_valid), .rsp_cmd(rsp_cmd), .rsp_address(rsp_address),
      .rsp_source(rsp_source), .rsp_payload(rsp_payload), .rsp_taken(rsp_taken),
      .num_reads(num_reads), .num_writes(num_writes)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int word_idx(input logic [31:0] a);
      return int'((a >> 3) & 32'(MEM_WORDS - 1));
   endfunction

   // pre_acc: request was already presented and accepted by the previous call (pend mode).
   // pend: while the response is held, present a second request that must wait.
   task automatic run_txn(input logic [1:0] cmd, input logic [31:0] addr, input logic [3:0] src,
                          input logic [63:0] pl, input int hold, input bit pre_acc,
                          input bit pend, input logic [1:0] p_cmd, input logic [31:0] p_addr,
                          input logic [3:0] p_src, input logic [63:0] p_pl);
      logic [1:0]  ecmd;
      logic [63:0] epl;
      int          k;
      int          idx;
      idx = word_idx(addr);
      if (addr[2:0] != 3'd0 || cmd > 2'd1) begin
         ecmd = RSP_ERROR; epl = 64'd0;
      end else if (cmd == CMD_READ) begin
         ecmd = RSP_READ_DATA; epl = mdl_mem.exists(idx) ? mdl_mem[idx] : 64'd0;
      end else begin
         ecmd = RSP_WRITE_ACK; epl = pl; mdl_mem[idx] = pl;
      end
      if (!pre_acc) begin
         @(posedge clk); #1;
         req_valid = 1'b1; req_cmd = cmd; req_address = addr;
         req_source = src; req_payload = pl;
         @(negedge clk);
         chk("accept_pulse", 64'(req_accept), 64'd1);
      end
      @(posedge clk); #1;
      req_valid   = ($urandom_range(0, 1) == 1);
      req_cmd     = 2'($urandom); req_address = $urandom;
      req_source  = 4'($urandom); req_payload = {$urandom, $urandom};
      for (k = 1; k <= 300; k++) begin
         @(negedge clk);
         if (rsp_valid) break;
         chk("busy_no_accept", 64'(req_accept), 64'd0);
         rsp_taken = ($urandom_range(0, 1) == 1);
      end
      rsp_taken = 1'b0;
      req_valid = 1'b0;
      chk("rsp_latency", 64'(k), 64'(LAT + 1));
      if (k > 300) return;
      chk("rsp_cmd", 64'(rsp_cmd), 64'(ecmd));
      chk("rsp_address", 64'(rsp_address), 64'(addr));
      chk("rsp_source", 64'(rsp_source), 64'(src));
      chk("rsp_payload", rsp_payload, epl);
      if (pend) begin
         req_valid = 1'b1; req_cmd = p_cmd; req_address = p_addr;
         req_source = p_src; req_payload = p_pl;
      end
      repeat (hold) begin
         @(negedge clk);
         chk("hold_valid", 64'(rsp_valid), 64'd1);
         chk("hold_payload", rsp_payload, epl);
         chk("hold_cmd", 64'(rsp_cmd), 64'(ecmd));
         chk("hold_no_accept", 64'(req_accept), 64'd0);
      end
      @(posedge clk); #1;
      rsp_taken = 1'b1;
      @(negedge clk);
      chk("taken_cycle_no_accept", 64'(req_accept), 64'd0);
      @(posedge clk); #1;
      rsp_taken = 1'b0;
      if (ecmd == RSP_READ_DATA) exp_reads++;
      if (ecmd == RSP_WRITE_ACK) exp_writes++;
      @(negedge clk);
      chk("num_reads", 64'(num_reads), 64'(exp_reads));
      chk("num_writes", 64'(num_writes), 64'(exp_writes));
      chk("valid_dropped", 64'(rsp_valid), 64'd0);
      if (pend) chk("accept_after_taken", 64'(req_accept), 64'd1);
   endtask

   task automatic txn(input logic [1:0] cmd, input logic [31:0] addr, input logic [3:0] src,
                      input logic [63:0] pl, input int hold);
      run_txn(cmd, addr, src, pl, hold, 1'b0, 1'b0, 2'd0, 32'd0, 4'd0, 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  r_cmd;
      logic [31:0] r_addr;
      int          sel;

      reset = 1'b1; req_valid = 1'b1; req_cmd = CMD_WRITE; req_address = 32'h40;
      req_source = 4'd1; req_payload = 64'hdead; rsp_taken = 1'b0;
      #3;
      chk("rst_accept", 64'(req_accept), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_cmd", 64'(rsp_cmd), 64'(RSP_ERROR));
      chk("rst_rsp_address", 64'(rsp_address), 64'd0);
      chk("rst_rsp_source", 64'(rsp_source), 64'd0);
      chk("rst_rsp_payload", rsp_payload, 64'd0);
      chk("rst_num_reads", 64'(num_reads), 64'd0);
      chk("rst_num_writes", 64'(num_writes), 64'd0);
      req_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      txn(CMD_WRITE, 32'h40, 4'd3, 64'h1122334455667788, 0);
      txn(CMD_READ, 32'h40, 4'd5, 64'd0, 2);
      txn(CMD_READ, 32'h2040, 4'd7, 64'd0, 1);
      txn(CMD_READ, 32'h43, 4'd2, 64'd0, 0);
      txn(2'd2, 32'h48, 4'd4, 64'h55, 0);

      // Response held 10 cycles with a WRITE pending, then that WRITE runs after rsp_taken.
      run_txn(CMD_READ, 32'h40, 4'd6, 64'd0, 10, 1'b0, 1'b1,
              CMD_WRITE, 32'h100, 4'd9, 64'hcafef00d12345678);
      run_txn(CMD_WRITE, 32'h100, 4'd9, 64'hcafef00d12345678, 0, 1'b1, 1'b0,
              2'd0, 32'd0, 4'd0, 64'd0);
      txn(CMD_READ, 32'h100, 4'd1, 64'd0, 0);

      // Reset while a WRITE to 0x80 is still waiting.
      @(posedge clk); #1;
      req_valid = 1'b1; req_cmd = CMD_WRITE; req_address = 32'h80;
      req_source = 4'd8; req_payload = 64'hffff0000ffff0000;
      @(negedge clk);
      chk("rstw_accept", 64'(req_accept), 64'd1);
      @(posedge clk); #1 req_valid = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      #1;
      exp_reads = 0; exp_writes = 0;
      chk("rstw_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rstw_num_reads", 64'(num_reads), 64'd0);
      chk("rstw_num_writes", 64'(num_writes), 64'd0);
      chk("rstw_rsp_payload", rsp_payload, 64'd0);
      @(posedge clk); #1 reset = 1'b0;
      repeat (10) begin
         @(negedge clk);
         chk("rstw_stays_idle", 64'(rsp_valid), 64'd0);
      end
      txn(CMD_READ, 32'h80, 4'd2, 64'd0, 0);

      for (int i = 0; i < 40; i++) begin
         sel = $urandom_range(0, 9);
         r_cmd = (sel < 4) ? CMD_READ : (sel < 8) ? CMD_WRITE : 2'($urandom_range(2, 3));
         r_addr = $urandom;
         r_addr[12:3] = {7'd0, 3'($urandom_range(0, 7))};
         r_addr[2:0] = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
         txn(r_cmd, r_addr, 4'($urandom), {$urandom, $urandom}, $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
